// File: rtl/rename_reg_file.sv
// Rename-aware architectural register file.
// Each register holds a value, a busy flag and the ROB tag of its pending
// producer. Reads are combinational with a same-cycle commit bypass; rename,
// commit and flush all take effect on the next rising edge while rdy is high.
module rename_reg_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic [$clog2(NREG)-1:0]   rs1,
    input  logic [$clog2(NREG)-1:0]   rs2,
    output logic                      rs1_ready,
    output logic [XLEN-1:0]           rs1_val,
    output logic [TAG_W-1:0]          rs1_tag,
    output logic                      rs2_ready,
    output logic [XLEN-1:0]           rs2_val,
    output logic [TAG_W-1:0]          rs2_tag,
    input  logic                      ren_en,
    input  logic [$clog2(NREG)-1:0]   ren_rd,
    input  logic [TAG_W-1:0]          ren_tag,
    input  logic                      cmt_en,
    input  logic [$clog2(NREG)-1:0]   cmt_rd,
    input  logic [TAG_W-1:0]          cmt_tag,
    input  logic [XLEN-1:0]           cmt_val,
    input  logic                      flush,
    output logic [$clog2(NREG):0]     busy_cnt
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]  val_r [NREG];
    logic [TAG_W-1:0] tag_r [NREG];
    logic [NREG-1:0]  busy_r;
    logic [NREG-1:0]  busy_nxt;

    logic cmt_live;
    logic ren_live;

    // x0 is hardwired, so rename/commit aimed at it are discarded up front.
    assign cmt_live = cmt_en && (cmt_rd != '0);
    assign ren_live = ren_en && (ren_rd != '0) && !flush;

    // Read one port: x0 constant, commit bypass on tag match, else stored state.
    function automatic logic [XLEN+TAG_W:0] read_port(input logic [AW-1:0] rs);
        logic hit;
        hit = cmt_en && (cmt_rd == rs) && busy_r[rs] && (tag_r[rs] == cmt_tag);
        if (rs == '0)
            read_port = {1'b1, {XLEN{1'b0}}, {TAG_W{1'b0}}};
        else if (hit)
            read_port = {1'b1, cmt_val, tag_r[rs]};
        else
            read_port = {~busy_r[rs], val_r[rs], tag_r[rs]};
    endfunction

    // Number of set bits in the busy vector.
    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        popcount = '0;
        for (int i = 0; i < NREG; i++)
            popcount = popcount + {{AW{1'b0}}, v[i]};
    endfunction

    // Combinational operand reads for both ports.
    always_comb begin
        {rs1_ready, rs1_val, rs1_tag} = read_port(rs1);
        {rs2_ready, rs2_val, rs2_tag} = read_port(rs2);
    end

    // Next busy vector: flush clears everything, commit clears on tag match,
    // and rename is applied last so it wins over a same-register commit.
    always_comb begin
        busy_nxt = busy_r;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (cmt_live && (tag_r[cmt_rd] == cmt_tag))
                busy_nxt[cmt_rd] = 1'b0;
            if (ren_live)
                busy_nxt[ren_rd] = 1'b1;
        end
    end

    // State update: reset dominates; rdy low freezes everything else.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r   <= '0;
            busy_cnt <= '0;
            for (int i = 0; i < NREG; i++) begin
                val_r[i] <= '0;
                tag_r[i] <= '0;
            end
        end else if (rdy) begin
            busy_r   <= busy_nxt;
            busy_cnt <= popcount(busy_nxt);
            if (cmt_live)
                val_r[cmt_rd] <= cmt_val;
            if (ren_live)
                tag_r[ren_rd] <= ren_tag;
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Scoreboard bench for rename_reg_file: a driver applies directed and random
// stimulus, predicts each cycle's outputs from an array-based model and queues
// them; a monitor on the falling edge pops and compares.
module tb_rename_reg_file;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 4;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst, rdy, flush;
    logic [AW-1:0]    rs1, rs2;
    logic             rs1_ready, rs2_ready;
    logic [XLEN-1:0]  rs1_val, rs2_val;
    logic [TAG_W-1:0] rs1_tag, rs2_tag;
    logic             ren_en, cmt_en;
    logic [AW-1:0]    ren_rd, cmt_rd;
    logic [TAG_W-1:0] ren_tag, cmt_tag;
    logic [XLEN-1:0]  cmt_val;
    logic [AW:0]      busy_cnt;

    rename_reg_file #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rs1(rs1), .rs2(rs2),
        .rs1_ready(rs1_ready), .rs1_val(rs1_val), .rs1_tag(rs1_tag),
        .rs2_ready(rs2_ready), .rs2_val(rs2_val), .rs2_tag(rs2_tag),
        .ren_en(ren_en), .ren_rd(ren_rd), .ren_tag(ren_tag),
        .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             r1;
        logic [XLEN-1:0]  v1;
        logic [TAG_W-1:0] t1;
        logic             r2;
        logic [XLEN-1:0]  v2;
        logic [TAG_W-1:0] t2;
        logic [AW:0]      cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: plain per-register arrays.
    logic [XLEN-1:0]  m_val  [NREG];
    logic             m_busy [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += m_busy[i] ? 1 : 0;
        return c;
    endfunction

    // Apply the inputs present at the edge that just occurred.
    function automatic void model_step();
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (rdy) begin
            if (cmt_en && cmt_rd != 0) begin
                m_val[cmt_rd] = cmt_val;
                if (m_tag[cmt_rd] == cmt_tag) m_busy[cmt_rd] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else if (ren_en && ren_rd != 0) begin
                m_busy[ren_rd] = 1'b1;
                m_tag[ren_rd]  = ren_tag;
            end
        end
    endfunction

    function automatic void model_read(input logic [AW-1:0] rs, output logic r,
                                       output logic [XLEN-1:0] v, output logic [TAG_W-1:0] t);
        if (rs == 0) begin
            r = 1'b1; v = '0; t = '0;
        end else if (cmt_en && cmt_rd == rs && m_busy[rs] && m_tag[rs] == cmt_tag) begin
            r = 1'b1; v = cmt_val; t = m_tag[rs];
        end else begin
            r = !m_busy[rs]; v = m_val[rs]; t = m_tag[rs];
        end
    endfunction

    task automatic issue();
        exp_t e;
        model_read(rs1, e.r1, e.v1, e.t1);
        model_read(rs2, e.r2, e.v2, e.t2);
        e.cnt = (AW+1)'(m_count());
        exp_q.push_back(e);
    endtask

    task automatic go();
        issue();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        ren_en = 1'b0; ren_rd = '0; ren_tag = '0;
        cmt_en = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_val = '0;
        rs1 = '0; rs2 = '0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rs1_ready", 64'(rs1_ready), 64'(e.r1));
                check("rs1_val",   64'(rs1_val),   64'(e.v1));
                if (!e.r1) check("rs1_tag", 64'(rs1_tag), 64'(e.t1));
                check("rs2_ready", 64'(rs2_ready), 64'(e.r2));
                check("rs2_val",   64'(rs2_val),   64'(e.v2));
                if (!e.r2) check("rs2_tag", 64'(rs2_tag), 64'(e.t2));
                check("busy_cnt",  64'(busy_cnt),  64'(e.cnt));
            end
        end
    end

    initial begin
        idle();
        rst = 1'b0; ren_en = 1'b1; ren_rd = 5'd3; cmt_en = 1'b1; cmt_rd = 5'd3;
        @(posedge clk); model_step(); #1;

        // Reset state across several registers.
        idle(); rst = 1'b0; rs1 = 5'd1; rs2 = 5'd31; go();
        idle(); rs1 = 5'd17; rs2 = 5'd0; go();

        // Rename then commit with matching tag.
        idle(); ren_en = 1'b1; ren_rd = 5'd5; ren_tag = 4'd3; rs1 = 5'd5; go();
        idle(); cmt_en = 1'b1; cmt_rd = 5'd5; cmt_tag = 4'd3; cmt_val = 32'hDEAD; rs1 = 5'd5; go();
        idle(); rs1 = 5'd5; go();

        // Stale-tag commit writes the value but leaves x7 busy.
        idle(); ren_en = 1'b1; ren_rd = 5'd7; ren_tag = 4'd2; go();
        idle(); ren_en = 1'b1; ren_rd = 5'd7; ren_tag = 4'd9; rs1 = 5'd7; go();
        idle(); cmt_en = 1'b1; cmt_rd = 5'd7; cmt_tag = 4'd2; cmt_val = 32'h11; rs1 = 5'd7; go();
        idle(); rs1 = 5'd7; go();
        idle(); cmt_en = 1'b1; cmt_rd = 5'd7; cmt_tag = 4'd9; cmt_val = 32'h22; rs2 = 5'd7; go();
        idle(); rs1 = 5'd7; go();

        // Commit bypass on read port 2.
        idle(); ren_en = 1'b1; ren_rd = 5'd3; ren_tag = 4'd4; go();
        idle(); cmt_en = 1'b1; cmt_rd = 5'd3; cmt_tag = 4'd4; cmt_val = 32'h55; rs2 = 5'd3; go();

        // Rename and commit to the same register in one cycle: rename wins.
        idle(); ren_en = 1'b1; ren_rd = 5'd10; ren_tag = 4'd1; go();
        idle(); ren_en = 1'b1; ren_rd = 5'd10; ren_tag = 4'd6;
        cmt_en = 1'b1; cmt_rd = 5'd10; cmt_tag = 4'd1; cmt_val = 32'hA5; rs1 = 5'd10; go();
        idle(); rs1 = 5'd10; go();

        // Flush with a same-cycle rename.
        idle(); ren_en = 1'b1; ren_rd = 5'd1; ren_tag = 4'd1; go();
        idle(); ren_en = 1'b1; ren_rd = 5'd2; ren_tag = 4'd2; go();
        idle(); ren_en = 1'b1; ren_rd = 5'd4; ren_tag = 4'd5; rs1 = 5'd1; go();
        idle(); flush = 1'b1; ren_en = 1'b1; ren_rd = 5'd6; ren_tag = 4'd7; rs1 = 5'd2; go();
        idle(); rs1 = 5'd6; rs2 = 5'd4; go();

        // x0 ignores rename and commit.
        idle(); ren_en = 1'b1; ren_rd = 5'd0; ren_tag = 4'd8;
        cmt_en = 1'b1; cmt_rd = 5'd0; cmt_val = 32'hFF; go();
        idle(); go();

        // rdy low freezes state.
        idle(); rdy = 1'b0; ren_en = 1'b1; ren_rd = 5'd9; ren_tag = 4'd3; rs1 = 5'd9; go();
        idle(); rs1 = 5'd9; go();

        // Reset during a commit.
        idle(); ren_en = 1'b1; ren_rd = 5'd8; ren_tag = 4'd1; go();
        idle(); rst = 1'b0; cmt_en = 1'b1; cmt_rd = 5'd8; cmt_tag = 4'd1;
        cmt_val = 32'h77; rs1 = 5'd8; go();
        idle(); rs1 = 5'd8; go();

        // Randomised traffic concentrated on a few registers to force collisions.
        for (int n = 0; n < 600; n++) begin
            idle();
            rst     = ($urandom_range(0, 99) != 0);
            rdy     = ($urandom_range(0, 9) != 0);
            flush   = ($urandom_range(0, 24) == 0);
            ren_en  = ($urandom_range(0, 1) == 1);
            ren_rd  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            ren_tag = TAG_W'($urandom);
            cmt_en  = ($urandom_range(0, 1) == 1);
            cmt_rd  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            cmt_tag = ($urandom_range(0, 2) != 0) ? m_tag[cmt_rd] : TAG_W'($urandom);
            cmt_val = $urandom;
            rs1     = ($urandom_range(0, 1) == 1) ? cmt_rd : AW'($urandom_range(0, 7));
            rs2     = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            go();
        end

        idle();
        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
